// File: rtl/quad_snapshot_reader_if.sv
// Host-side byte bus of the quadrature snapshot reader: latch/rd strobes in,
// snapshot byte stream and status out.
interface quad_snapshot_reader_if;
    logic       latch;
    logic       rd;
    logic [7:0] dout;
    logic       valid;
    logic       ovr;

    modport master (output latch, rd, input dout, valid, ovr);
    modport slave  (input latch, rd, output dout, valid, ovr);
endinterface

// File: rtl/quad_snapshot_reader.sv
// Coherent multi-axis snapshot of {zl, i, c} counter words, streamed to the host
// one byte per rd strobe; returns zr once each latched index word has been read.
// Optional trailing mod-256 checksum byte: define QUAD_SNAPSHOT_CKSUM_EN.

// One channel's frozen word, zero-padded out to a whole number of bytes.
module quad_snapshot_lane #(
    parameter int W = 14,
    localparam int BPC = (2*W+8)/8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic [2*W:0]     din,
    output logic [BPC*8-1:0] snap_bytes,
    output logic             zl
);
    logic [2*W:0] snap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      snap <= '0;
        else if (cap) snap <= din;
    end

    assign snap_bytes = (BPC*8)'(snap);
    assign zl         = snap[2*W];
endmodule

module quad_snapshot_reader #(
    parameter int W   = 14,
    parameter int NCH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH*(2*W+1)-1:0]   quad_in,
    output logic [NCH-1:0]           zr_out,
    quad_snapshot_reader_if.slave    host
);
    localparam int CW  = 2*W+1;
    localparam int BPC = (CW+7)/8;
    localparam int CHW = $clog2(NCH+1);
    localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;

    typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

    state_t                   state, state_nx;
    logic [CHW-1:0]           chan;
    logic [BW-1:0]            bsel;
    logic [NCH-1:0][BPC*8-1:0] lane_bytes;
    logic [NCH-1:0]           snap_zl;
    logic [7:0]               sel_byte;
    logic                     rd_ok;
    logic                     chan_end;
    logic                     last_byte;

    // latch outranks rd, so a same-cycle rd never advances the pointer
    assign rd_ok    = host.rd && !host.latch && (state == SERVE);
    assign chan_end = (bsel == BW'(BPC-1)) && (chan < CHW'(NCH));

    for (genvar n = 0; n < NCH; n++) begin : g_lane
        quad_snapshot_lane #(.W(W)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .cap        (host.latch),
            .din        (quad_in[n*CW +: CW]),
            .snap_bytes (lane_bytes[n]),
            .zl         (snap_zl[n])
        );
    end

`ifdef QUAD_SNAPSHOT_CKSUM_EN
    logic [7:0]       cksum, cksum_nx;
    logic [BPC*8-1:0] wpad;

    // Summed from the live inputs so it is ready on the same edge as the snapshot
    always_comb begin
        cksum_nx = '0;
        wpad     = '0;
        for (int n = 0; n < NCH; n++) begin
            wpad = (BPC*8)'(quad_in[n*CW +: CW]);
            for (int b = 0; b < BPC; b++)
                cksum_nx = cksum_nx + wpad[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             cksum <= '0;
        else if (host.latch) cksum <= cksum_nx;
    end

    assign last_byte = (chan == CHW'(NCH));
`else
    assign last_byte = (chan == CHW'(NCH-1)) && (bsel == BW'(BPC-1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (host.latch) state_nx = SERVE;
            SERVE: begin
                if (host.latch)                  state_nx = SERVE;
                else if (host.rd && last_byte)   state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Pointer is {channel, byte-in-channel}; it only ever counts up within a snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan <= '0;
            bsel <= '0;
        end else if (host.latch) begin
            chan <= '0;
            bsel <= '0;
        end else if (rd_ok) begin
            if (bsel == BW'(BPC-1)) begin
                bsel <= '0;
                chan <= chan + 1'b1;
            end else begin
                bsel <= bsel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zr_out <= '0;
        end else begin
            zr_out <= '0;
            if (rd_ok && chan_end)
                for (int n = 0; n < NCH; n++)
                    if (chan == CHW'(n)) zr_out[n] <= snap_zl[n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              host.ovr <= 1'b0;
        else if (host.latch)                  host.ovr <= 1'b0;
        else if (host.rd && state != SERVE)   host.ovr <= 1'b1;
    end

    always_comb begin
        sel_byte = '0;
        for (int n = 0; n < NCH; n++)
            for (int b = 0; b < BPC; b++)
                if (chan == CHW'(n) && bsel == BW'(b))
                    sel_byte = lane_bytes[n][8*b +: 8];
    end

    always_comb begin
        host.valid = (state == SERVE);
        host.dout  = '0;
        if (state == SERVE) begin
`ifdef QUAD_SNAPSHOT_CKSUM_EN
            host.dout = (chan == CHW'(NCH)) ? cksum : sel_byte;
`else
            host.dout = sel_byte;
`endif
        end
    end
endmodule

// File: tb/tb_quad_snapshot_reader.sv
// Scoreboard bench for quad_snapshot_reader: directed packing/overrun/reset cases
// followed by randomized latch/rd traffic against a byte-stream reference model.
module tb_quad_snapshot_reader;
    localparam int W   = 14;
    localparam int NCH = 4;
    localparam int CW  = 2*W+1;
    localparam int BPC = (CW+7)/8;
`ifdef QUAD_SNAPSHOT_CKSUM_EN
    localparam int NB = NCH*BPC + 1;
`else
    localparam int NB = NCH*BPC;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NCH*CW-1:0]   quad_in;
    logic [NCH-1:0]      zr_out;
    logic                scramble = 1'b0;

    quad_snapshot_reader_if hif();

    quad_snapshot_reader #(.W(W), .NCH(NCH)) dut (
        .clk     (clk),
        .rst     (rst),
        .quad_in (quad_in),
        .zr_out  (zr_out),
        .host    (hif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]     b;
        logic [NCH-1:0] zr;
    } ent_t;

    ent_t           exp_q[$];
    logic           exp_ovr = 1'b0;
    logic [NCH-1:0] exp_zr  = '0;
    int             checks  = 0;
    int             fails   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected stream: each channel word as a number, bytes peeled LSB first
    function automatic void build(input logic [NCH*CW-1:0] q);
        logic [63:0] wd;
        logic [7:0]  sum;
        ent_t        e;
        exp_q.delete();
        sum = 8'h00;
        for (int n = 0; n < NCH; n++) begin
            wd = 64'(q[n*CW +: CW]);
            for (int b = 0; b < BPC; b++) begin
                e.b  = 8'((wd >> (8*b)) & 64'hFF);
                e.zr = (b == BPC-1 && wd[2*W]) ? NCH'(1 << n) : '0;
                exp_q.push_back(e);
                sum = sum + e.b;
            end
        end
`ifdef QUAD_SNAPSHOT_CKSUM_EN
        e.b  = sum;
        e.zr = '0;
        exp_q.push_back(e);
`endif
    endfunction

    function automatic logic [NCH*CW-1:0] rand_quad();
        logic [NCH*CW-1:0] q;
        for (int n = 0; n < NCH; n++) q[n*CW +: CW] = CW'($urandom);
        return q;
    endfunction

    // Monitor: compare what the DUT shows now, then advance the model by this cycle's inputs
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_ovr = 1'b0;
            exp_zr  = '0;
        end else begin
            chk("valid", 32'(hif.valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("dout", 32'(hif.dout), 32'(exp_q[0].b));
            else                  chk("dout_idle", 32'(hif.dout), 32'h0);
            chk("ovr", 32'(hif.ovr), 32'(exp_ovr));
            chk("zr_out", 32'(zr_out), 32'(exp_zr));
            chk("zr_onehot", 32'($onehot0(zr_out)), 32'h1);
            exp_zr = '0;
            if (hif.latch) begin
                build(quad_in);
                exp_ovr = 1'b0;
            end else if (hif.rd) begin
                if (exp_q.size() > 0) begin
                    exp_zr = exp_q[0].zr;
                    void'(exp_q.pop_front());
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
    end

    task automatic step(input logic l, input logic r);
        @(posedge clk);
        #1;
        hif.latch = l;
        hif.rd    = r;
        if (scramble) quad_in = rand_quad();
    endtask

    task automatic rd_pulse();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    logic [7:0] lit [8];

    initial begin
        lit = '{8'h34, 8'h12, 8'hAF, 8'h12, 8'hFF, 8'h3F, 8'h00, 8'h00};
        hif.latch = 1'b0;
        hif.rd    = 1'b0;
        quad_in   = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_valid", 32'(hif.valid), 32'h0);
        chk("rst_dout", 32'(hif.dout), 32'h0);
        chk("rst_ovr", 32'(hif.ovr), 32'h0);
        rd_pulse();
        @(negedge clk);
        chk("idle_rd_ovr", 32'(hif.ovr), 32'h1);
        chk("idle_rd_valid", 32'(hif.valid), 32'h0);

        // ch0: c=0x1234 i=0x0ABC zl=1; ch1: c=0x3FFF i=0 zl=0
        quad_in = rand_quad();
        quad_in[0*CW +: CW] = {1'b1, 14'h0ABC, 14'h1234};
        quad_in[1*CW +: CW] = {1'b0, 14'h0000, 14'h3FFF};
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("pack_byte", 32'(hif.dout), 32'(lit[k]));
            if (k == 0) chk("latch_clr_ovr", 32'(hif.ovr), 32'h0);
            if (k == 4) chk("zr0_pulse", 32'(zr_out), 32'h1);
            if (k == 5) chk("zr0_single", 32'(zr_out), 32'h0);
            rd_pulse();
        end
        @(negedge clk);
        chk("zr1_none", 32'(zr_out), 32'h0);
        for (int k = 8; k < NB; k++) rd_pulse();
        @(negedge clk);
        chk("end_valid", 32'(hif.valid), 32'h0);
        chk("end_dout", 32'(hif.dout), 32'h0);
        rd_pulse();
        @(negedge clk);
        chk("overrun", 32'(hif.ovr), 32'h1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        chk("relatch_ovr", 32'(hif.ovr), 32'h0);
        chk("relatch_valid", 32'(hif.valid), 32'h1);

        // Coherency: inputs churn every cycle after the latch edge
        scramble = 1'b1;
        step(1'b1, 1'b0);
        for (int k = 0; k < NB; k++) rd_pulse();

        // Collision mid-stream: latch wins, rd dropped
        step(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) rd_pulse();
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int k = 0; k < NB; k++) rd_pulse();
        scramble = 1'b0;

        // Reset while a zr pulse is on the wire
        quad_in[0*CW +: CW] = {1'b1, 14'h1555, 14'h2AAA};
        step(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) rd_pulse();
        step(1'b0, 1'b1);
        @(posedge clk);
        #1 hif.rd = 1'b0;
        chk("pre_rst_zr", 32'(zr_out), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", 32'(hif.dout), 32'h0);
        chk("arst_valid", 32'(hif.valid), 32'h0);
        chk("arst_zr", 32'(zr_out), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_zr", 32'(zr_out), 32'h0);
        rd_pulse();
        rd_pulse();
        @(negedge clk);
        chk("post_rst_ovr", 32'(hif.ovr), 32'h1);

        // Random traffic
        scramble = 1'b1;
        for (int c = 0; c < 1500; c++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1);
        step(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
